// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB bus arbiter.
// Holds the FSM encoding, the requester id type and the timeout read data.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t     REQ_CPU           = 1'b0;
    localparam req_id_t     REQ_DMA           = 1'b1;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Writes hand zero back to the requester; reads pass the bus data through.
    function automatic logic [31:0] capture_rdata(input logic is_write, input logic [31:0] bus_rdata);
        logic [31:0] data_s;
        if (is_write) begin
            data_s = 32'h0000_0000;
        end else begin
            data_s = bus_rdata;
        end
        return data_s;
    endfunction

endpackage

// File: rtl/apb_bus_arbiter_if.sv
// Bundle of the two requester ports and the APB master-side ports.
// The arbiter uses the master modport; the surrounding system uses slave.
interface apb_bus_arbiter_if;

    logic        r0_transfer;
    logic        r0_write;
    logic [31:0] r0_addr;
    logic [31:0] r0_wdata;
    logic [31:0] r0_rdata;
    logic        r0_ready;
    logic        r0_err;

    logic        r1_transfer;
    logic        r1_write;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    logic [31:0] r1_rdata;
    logic        r1_ready;
    logic        r1_err;

    logic        m_transfer;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    modport master (
        input  r0_transfer, r0_write, r0_addr, r0_wdata,
        output r0_rdata, r0_ready, r0_err,
        input  r1_transfer, r1_write, r1_addr, r1_wdata,
        output r1_rdata, r1_ready, r1_err,
        output m_transfer, m_write, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport slave (
        output r0_transfer, r0_write, r0_addr, r0_wdata,
        input  r0_rdata, r0_ready, r0_err,
        output r1_transfer, r1_write, r1_addr, r1_wdata,
        input  r1_rdata, r1_ready, r1_err,
        input  m_transfer, m_write, m_addr, m_wdata,
        output m_rdata, m_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Stateless two-way round-robin pick; the caller owns the last-grant flop.
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic       grant_valid,
    output req_id_t    grant_id
);

    // A tie goes to whichever requester was not served last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = REQ_CPU;
        case (req)
            2'b01: begin
                grant_valid = 1'b1;
                grant_id    = REQ_CPU;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_id    = REQ_DMA;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end
            default: begin
                grant_valid = 1'b0;
                grant_id    = REQ_CPU;
            end
        endcase
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Shares one APB master between a CPU (id 0) and a DMA (id 1) requester,
// one transaction at a time, with a WAIT-state timeout that returns ERR_RDATA.
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_bus_arbiter_if.master bus
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_r;
    req_id_t          last_grant_r;
    req_id_t          grant_id_r;
    logic             m_transfer_r;
    logic [CNT_W-1:0] cnt_r;
    logic             hold_write_r;
    logic [31:0]      hold_addr_r;
    logic [31:0]      hold_wdata_r;
    logic             r0_ready_r;
    logic [31:0]      r0_rdata_r;
    logic             r0_err_r;
    logic             r1_ready_r;
    logic [31:0]      r1_rdata_r;
    logic             r1_err_r;

    logic [1:0]       req_s;
    logic             grant_valid_s;
    req_id_t          grant_id_s;
    logic             bus_done_s;
    logic             timeout_s;
    logic [31:0]      resp_rdata_s;
    logic             resp_err_s;

    assign req_s = {bus.r1_transfer, bus.r0_transfer};

    rr_arb2 u_rr_arb2 (
        .req         (req_s),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // WAIT exit conditions; m_ready wins over a timeout landing in the same cycle.
    always_comb begin
        bus_done_s = 1'b0;
        timeout_s  = 1'b0;
        if (state_r == WAIT) begin
            if (bus.m_ready) begin
                bus_done_s = 1'b1;
            end else if (cnt_r == CNT_MAX) begin
                timeout_s = 1'b1;
            end else begin
                timeout_s = 1'b0;
            end
        end else begin
            bus_done_s = 1'b0;
            timeout_s  = 1'b0;
        end
    end

    // Data and error flag handed back to the granted requester.
    always_comb begin
        resp_rdata_s = 32'h0000_0000;
        resp_err_s   = 1'b0;
        if (timeout_s) begin
            resp_rdata_s = ERR_RDATA;
            resp_err_s   = 1'b1;
        end else begin
            resp_rdata_s = capture_rdata(hold_write_r, bus.m_rdata);
            resp_err_s   = 1'b0;
        end
    end

    // Sequencer: request sampling, bus start pulse and WAIT cycle counting.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_r      <= IDLE;
            last_grant_r <= REQ_DMA;
            grant_id_r   <= REQ_CPU;
            m_transfer_r <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_r      <= START;
                        last_grant_r <= grant_id_s;
                        grant_id_r   <= grant_id_s;
                        m_transfer_r <= 1'b1;
                    end
                end
                START: begin
                    state_r      <= WAIT;
                    m_transfer_r <= 1'b0;
                    cnt_r        <= {CNT_W{1'b0}};
                end
                WAIT: begin
                    if (bus_done_s || timeout_s) begin
                        state_r <= RESP;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    m_transfer_r <= 1'b0;
                end
            endcase
        end
    end

    // Holding registers: the granted request is frozen here for the whole transaction.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            hold_write_r <= 1'b0;
            hold_addr_r  <= 32'h0000_0000;
            hold_wdata_r <= 32'h0000_0000;
        end else if ((state_r == IDLE) && grant_valid_s) begin
            hold_write_r <= (grant_id_s == REQ_DMA) ? bus.r1_write : bus.r0_write;
            hold_addr_r  <= (grant_id_s == REQ_DMA) ? bus.r1_addr  : bus.r0_addr;
            hold_wdata_r <= (grant_id_s == REQ_DMA) ? bus.r1_wdata : bus.r0_wdata;
        end
    end

    // Response registers: only the granted side sees a one-cycle ready in RESP.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r0_ready_r <= 1'b0;
            r0_rdata_r <= 32'h0000_0000;
            r0_err_r   <= 1'b0;
            r1_ready_r <= 1'b0;
            r1_rdata_r <= 32'h0000_0000;
            r1_err_r   <= 1'b0;
        end else begin
            case (state_r)
                WAIT: begin
                    if (bus_done_s || timeout_s) begin
                        if (grant_id_r == REQ_DMA) begin
                            r1_ready_r <= 1'b1;
                            r1_rdata_r <= resp_rdata_s;
                            r1_err_r   <= resp_err_s;
                        end else begin
                            r0_ready_r <= 1'b1;
                            r0_rdata_r <= resp_rdata_s;
                            r0_err_r   <= resp_err_s;
                        end
                    end
                end
                default: begin
                    r0_ready_r <= 1'b0;
                    r0_rdata_r <= 32'h0000_0000;
                    r0_err_r   <= 1'b0;
                    r1_ready_r <= 1'b0;
                    r1_rdata_r <= 32'h0000_0000;
                    r1_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_transfer = m_transfer_r;
    assign bus.m_write    = hold_write_r;
    assign bus.m_addr     = hold_addr_r;
    assign bus.m_wdata    = hold_wdata_r;
    assign bus.r0_ready   = r0_ready_r;
    assign bus.r0_rdata   = r0_rdata_r;
    assign bus.r0_err     = r0_err_r;
    assign bus.r1_ready   = r1_ready_r;
    assign bus.r1_rdata   = r1_rdata_r;
    assign bus.r1_err     = r1_err_r;

endmodule

// File: doc/apb_bus_arbiter.md
APB_BUS_ARBITER -- requirements
Module: apb_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, giving the number of WAIT cycles without master ready before the transaction aborts (range 2..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, giving the read data returned on a timed-out transaction.
REQ-003 SHALL have one clock and an asynchronous active-low reset:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous reset, active-low.
REQ-004 SHALL have these requester 0 ports (CPU, index 0):
- r0_transfer  in  1  request, level, held until r0_ready.
- r0_write  in  1  1 = write.
- r0_addr  in  32  address.
- r0_wdata  in  32  write data.
- r0_rdata  out  32  read data.
- r0_ready  out  1  completion pulse.
- r0_err  out  1  timeout flag, valid with r0_ready.
REQ-005 SHALL have requester 1 ports (DMA) r1_transfer, r1_write, r1_addr, r1_wdata, r1_rdata, r1_ready, r1_err, identical to REQ-004.
REQ-006 SHALL have these APB master-side ports:
- m_transfer  out  1  one-cycle start pulse.
- m_write  out  1  write.
- m_addr  out  32  address.
- m_wdata  out  32  write data.
- m_rdata  in  32  read data.
- m_ready  in  1  master completion.

Function
REQ-007 SHALL implement FSM states IDLE, START, WAIT, RESP.
REQ-008 IDLE: if any rX_transfer is high, SHALL select a winner per REQ-012, latch its write/addr/wdata into holding registers, record its id, and go to START; otherwise stay in IDLE.
REQ-009 START: SHALL assert m_transfer for exactly one cycle and drive m_write/m_addr/m_wdata from the holding registers, then go to WAIT.
REQ-010 WAIT: SHALL hold m_write/m_addr/m_wdata stable; on m_ready SHALL latch m_rdata (reads only; writes latch 0) and go to RESP; the timeout counter SHALL increment each WAIT cycle.
REQ-011 RESP: SHALL pulse ready of the granted requester for one cycle with rdata driven from the latch, then go to IDLE. The non-granted requester's ready, rdata and err SHALL stay 0.
REQ-012 SHALL arbitrate round-robin with a last_grant flop:
- only one requester high: that one wins;
- both high: the requester not equal to last_grant wins;
- last_grant updates on every IDLE->START.
REQ-013 Request-to-m_transfer latency SHALL be 1 cycle. m_ready-to-rX_ready latency SHALL be 1 cycle. Minimum transaction is 4 cycles (IDLE, START, WAIT, RESP).
REQ-014 A request withdrawn before it is sampled in IDLE SHALL be ignored. Changes to rX_* inputs after latching SHALL NOT affect the bus transaction.
REQ-015 Timeout: if the counter reaches TIMEOUT_CYCLES-1 in WAIT with m_ready low, the block SHALL go to RESP with rdata=ERR_RDATA and err=1. An m_ready arriving in that same cycle SHALL take priority (normal completion, err=0).
REQ-016 The timeout counter SHALL clear on entering WAIT. Its width is $clog2(TIMEOUT_CYCLES); the counter SHALL NOT wrap.
REQ-017 m_ready outside WAIT SHALL be ignored.
REQ-018 The block SHALL accept no new request while not in IDLE: one outstanding transaction maximum.

Reset
REQ-019 While PRESET=0, the block SHALL be in state IDLE, last_grant=1 (so requester 0 wins the first tie), and all outputs, holding registers and the counter SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abort it with no ready pulse issued. After release the block SHALL sample requests in IDLE on the first PCLK edge.

Structure
REQ-021 Package apb_arb_pkg SHALL hold the state enum (IDLE, START, WAIT, RESP), the requester-id typedef (1 bit), and the default ERR_RDATA constant.
REQ-022 Round-robin selection SHALL be a sub-module rr_arb2 with inputs req[1:0], last_grant and outputs grant_valid, grant_id; it is combinational and owns no state.

Verification
REQ-023 Single read: r0 reads 0x1000_0004, m_ready 3 cycles after m_transfer with m_rdata=0x1234_5678 -> m_transfer 1 cycle after request; r0_ready with r0_rdata=0x1234_5678 and r0_err=0 one cycle after m_ready.
REQ-024 Simultaneous requests from reset: r0 writes 0xA5 to 0x1000_0000, r1 reads 0x1000_0008 -> r0 served first, r1 second; then simultaneous again -> r0 first (alternates).
REQ-025 Back-to-back r1 only, three transactions -> all granted to r1, each taking 4 cycles when m_ready returns immediately.
REQ-026 Timeout with TIMEOUT_CYCLES=8 and m_ready never returned -> r0_ready with r0_rdata=0xDEAD_BEEF and r0_err=1 eight cycles after entering WAIT; m_ready in the final cycle -> normal data, err=0.
REQ-027 PRESET low during WAIT -> no rX_ready pulse, all outputs 0; a post-reset request completes normally.
REQ-028 Changing r0_addr after the grant -> m_addr unchanged for the whole transaction.
